// File: rtl/memory_stage.sv
// Memory stage of the RV32I pipeline: bus handshake for loads/stores and registered writeback.
// Optional MISALIGN_TRAP_EN turns misaligned halfword/word accesses into traps instead of aligning.
module memory_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        execute_valid_i,
  input  logic [4:0]  execute_rd_i,
  input  logic        execute_rd_wr_en_i,
  input  logic [31:0] execute_rd_wr_data_i,
  input  logic        execute_is_load_i,
  input  logic        execute_is_store_i,
  input  logic [2:0]  execute_funct3_i,
  input  logic [31:0] execute_mem_addr_i,
  input  logic [31:0] execute_store_data_i,
  output logic        memory_stall_o,
  output logic        memory_clk_en_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        writeback_clk_en_o,
  output logic [4:0]  writeback_rd_o,
  output logic        writeback_rd_wr_en_o,
  output logic [31:0] writeback_rd_wr_data_o,
  output logic        memory_misaligned_o,
  output logic [31:0] memory_bad_addr_o
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;

  // Instruction currently held by the stage
  logic        valid_q, valid_d;
  logic [4:0]  rd_q;
  logic        rd_wr_en_q;
  logic [31:0] alu_q;
  logic        is_load_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        mis_q;

  // Bus outputs
  logic        req_q, req_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Writeback record
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_wr_en_q, wb_wr_en_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        stall;
  logic        capture;
  logic        mem_op;
  logic        mis_c;
  logic        issue;
  logic        retire_nm;
  logic        retire_mem;
  logic        retire;
  logic [1:0]  off_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [31:0] shifted;
  logic [31:0] load_c;

  assign stall   = (state_q == StWait) && !dmem_ack_i;
  assign capture = execute_valid_i && !stall;
  assign mem_op  = execute_is_load_i || execute_is_store_i;

`ifdef MISALIGN_TRAP_EN
  assign mis_c = mem_op &&
                 ((((execute_funct3_i == 3'b001) ||
                    ((execute_funct3_i == 3'b101) && execute_is_load_i)) &&
                   execute_mem_addr_i[0]) ||
                  ((execute_funct3_i == 3'b010) && (execute_mem_addr_i[1:0] != 2'b00)));
`else
  assign mis_c = 1'b0;
`endif

  assign issue = capture && mem_op && !mis_c;

  // Byte offset is forced to natural alignment; misaligned cases never reach the bus when trapping
  always_comb begin
    off_c   = 2'b00;
    wdata_c = execute_store_data_i;
    wstrb_c = 4'b0000;
    case (execute_funct3_i[1:0])
      2'b00: begin
        off_c   = execute_mem_addr_i[1:0];
        wdata_c = {4{execute_store_data_i[7:0]}};
        wstrb_c = 4'b0001 << execute_mem_addr_i[1:0];
      end
      2'b01: begin
        off_c   = {execute_mem_addr_i[1], 1'b0};
        wdata_c = {2{execute_store_data_i[15:0]}};
        wstrb_c = 4'b0011 << {execute_mem_addr_i[1], 1'b0};
      end
      2'b10: begin
        wstrb_c = 4'b1111;
      end
      default: begin
        wstrb_c = 4'b0000;
      end
    endcase
  end

  assign shifted = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_c = 32'h0;
    case (funct3_q)
      3'b000:  load_c = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_c = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_c = shifted;
      3'b100:  load_c = {24'h0, shifted[7:0]};
      3'b101:  load_c = {16'h0, shifted[15:0]};
      default: load_c = 32'h0;
    endcase
  end

  // Non-memory (and trapped) instructions never enter WAIT, so they retire from IDLE
  assign retire_nm  = (state_q == StIdle) && valid_q;
  assign retire_mem = (state_q == StWait) && dmem_ack_i;
  assign retire     = retire_nm || retire_mem;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = issue ? StWait : StIdle;
      StWait:  state_d = (issue || stall) ? StWait : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d    = capture ? 1'b1 : (stall ? valid_q : 1'b0);
    req_d      = issue || stall;
    wb_en_d    = retire;
    wb_rd_d    = wb_rd_q;
    wb_wr_en_d = 1'b0;
    wb_data_d  = wb_data_q;
    if (retire) begin
      wb_rd_d    = rd_q;
      wb_wr_en_d = rd_wr_en_q && (rd_q != 5'd0) && !is_store_q && !mis_q;
      wb_data_d  = is_load_q ? load_c : alu_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      rd_wr_en_q <= 1'b0;
      alu_q      <= 32'h0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      mis_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'b0000;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_wr_en_q <= 1'b0;
      wb_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_data_q  <= wb_data_d;
      if (capture) begin
        rd_q       <= execute_rd_i;
        rd_wr_en_q <= execute_rd_wr_en_i;
        alu_q      <= execute_rd_wr_data_i;
        is_load_q  <= execute_is_load_i;
        is_store_q <= execute_is_store_i;
        funct3_q   <= execute_funct3_i;
        off_q      <= off_c;
        mis_q      <= mis_c;
      end
      if (issue) begin
        we_q    <= execute_is_store_i;
        addr_q  <= {execute_mem_addr_i[31:2], 2'b00};
        wdata_q <= wdata_c;
        wstrb_q <= wstrb_c;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic [31:0] bad_addr_q;
  logic        wb_mis_q;
  logic [31:0] wb_bad_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad_addr_q    <= 32'h0;
      wb_mis_q      <= 1'b0;
      wb_bad_addr_q <= 32'h0;
    end else begin
      if (capture) begin
        bad_addr_q <= execute_mem_addr_i;
      end
      wb_mis_q <= retire_nm && mis_q;
      if (retire) begin
        wb_bad_addr_q <= mis_q ? bad_addr_q : 32'h0;
      end
    end
  end

  assign memory_misaligned_o = wb_mis_q;
  assign memory_bad_addr_o   = wb_bad_addr_q;
`else
  assign memory_misaligned_o = 1'b0;
  assign memory_bad_addr_o   = 32'h0;
`endif

  assign memory_stall_o         = stall;
  assign memory_clk_en_o        = valid_q;
  assign dmem_req_o             = req_q;
  assign dmem_we_o              = we_q;
  assign dmem_addr_o            = addr_q;
  assign dmem_wdata_o           = wdata_q;
  assign dmem_wstrb_o           = wstrb_q;
  assign writeback_clk_en_o     = wb_en_q;
  assign writeback_rd_o         = wb_rd_q;
  assign writeback_rd_wr_en_o   = wb_wr_en_q;
  assign writeback_rd_wr_data_o = wb_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: hand-computed vectors checked with immediate assertions.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [31:0] ex_data;
  logic        ex_ld;
  logic        ex_st;
  logic [2:0]  ex_f3;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic        stall;
  logic        clk_en;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic        mis;
  logic [31:0] bad_addr;

  int n_total = 0;
  int n_pass  = 0;

  memory_stage dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .execute_valid_i        (ex_valid),
    .execute_rd_i           (ex_rd),
    .execute_rd_wr_en_i     (ex_wen),
    .execute_rd_wr_data_i   (ex_data),
    .execute_is_load_i      (ex_ld),
    .execute_is_store_i     (ex_st),
    .execute_funct3_i       (ex_f3),
    .execute_mem_addr_i     (ex_addr),
    .execute_store_data_i   (ex_sdata),
    .memory_stall_o         (stall),
    .memory_clk_en_o        (clk_en),
    .dmem_req_o             (req),
    .dmem_we_o              (we),
    .dmem_addr_o            (addr),
    .dmem_wdata_o           (wdata),
    .dmem_wstrb_o           (wstrb),
    .dmem_ack_i             (ack),
    .dmem_rdata_i           (rdata),
    .writeback_clk_en_o     (wb_en),
    .writeback_rd_o         (wb_rd),
    .writeback_rd_wr_en_o   (wb_wen),
    .writeback_rd_wr_data_o (wb_data),
    .memory_misaligned_o    (mis),
    .memory_bad_addr_o      (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                       input logic [31:0] d, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    ex_valid = v;
    ex_rd    = rd;
    ex_wen   = wen;
    ex_data  = d;
    ex_ld    = ld;
    ex_st    = st;
    ex_f3    = f3;
    ex_addr  = a;
    ex_sdata = sd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    ack   = 1'b0;
    rdata = 32'h0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick;
    tick;
    chk("rst_wb_en", {31'h0, wb_en}, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_clk_en", {31'h0, clk_en}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    neg;
    rst = 1'b0;

    // ADD rd=5 -> writeback one edge after capture, no bus traffic
    drive(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick;
    chk("add_clk_en", {31'h0, clk_en}, 32'h1);
    chk("add_wb_early", {31'h0, wb_en}, 32'h0);
    neg;
    ex_valid = 1'b0;
    tick;
    chk("add_wb_en", {31'h0, wb_en}, 32'h1);
    chk("add_wb_rd", {27'h0, wb_rd}, 32'd5);
    chk("add_wb_wen", {31'h0, wb_wen}, 32'h1);
    chk("add_wb_data", wb_data, 32'h00001234);
    chk("add_req", {31'h0, req}, 32'h0);
    chk("add_clk_en_clr", {31'h0, clk_en}, 32'h0);
    tick;
    chk("add_wb_pulse_end", {31'h0, wb_en}, 32'h0);

    // Back-to-back ADDs, first targets x0
    neg;
    drive(1'b1, 5'd0, 1'b1, 32'h77, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    neg;
    drive(1'b1, 5'd3, 1'b1, 32'h99, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick;
    chk("x0_wb_en", {31'h0, wb_en}, 32'h1);
    chk("x0_wb_wen", {31'h0, wb_wen}, 32'h0);
    neg;
    ex_valid = 1'b0;
    tick;
    chk("add2_wb_en", {31'h0, wb_en}, 32'h1);
    chk("add2_wb_rd", {27'h0, wb_rd}, 32'd3);
    chk("add2_wb_data", wb_data, 32'h99);
    tick;

    // LB 0x102, ack in the third request cycle
    neg;
    drive(1'b1, 5'd6, 1'b1, 32'hDEAD, 1'b1, 1'b0, 3'b000, 32'h102, 32'h0);
    tick;
    chk("lb_req", {31'h0, req}, 32'h1);
    chk("lb_we", {31'h0, we}, 32'h0);
    chk("lb_addr", addr, 32'h100);
    chk("lb_stall1", {31'h0, stall}, 32'h1);
    neg;
    ex_valid = 1'b0;
    tick;
    chk("lb_stall2", {31'h0, stall}, 32'h1);
    chk("lb_req_hold", {31'h0, req}, 32'h1);
    chk("lb_clk_en_hold", {31'h0, clk_en}, 32'h1);
    chk("lb_no_wb", {31'h0, wb_en}, 32'h0);
    neg;
    ack   = 1'b1;
    rdata = 32'h00800000;
    #1;
    chk("lb_stall_ack", {31'h0, stall}, 32'h0);
    tick;
    chk("lb_wb_en", {31'h0, wb_en}, 32'h1);
    chk("lb_wb_rd", {27'h0, wb_rd}, 32'd6);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    chk("lb_req_clr", {31'h0, req}, 32'h0);
    neg;
    ack = 1'b0;

    // LBU 0x102, ack in the first request cycle
    drive(1'b1, 5'd6, 1'b1, 32'h0, 1'b1, 1'b0, 3'b100, 32'h102, 32'h0);
    tick;
    neg;
    ex_valid = 1'b0;
    ack      = 1'b1;
    tick;
    chk("lbu_wb_data", wb_data, 32'h00000080);
    neg;
    ack = 1'b0;

    // SH 0x206
    drive(1'b1, 5'd7, 1'b1, 32'h0, 1'b0, 1'b1, 3'b001, 32'h206, 32'hABCD1234);
    tick;
    chk("sh_req", {31'h0, req}, 32'h1);
    chk("sh_we", {31'h0, we}, 32'h1);
    chk("sh_addr", addr, 32'h204);
    chk("sh_wstrb", {28'h0, wstrb}, 32'hC);
    chk("sh_wdata", wdata, 32'h12341234);
    neg;
    ex_valid = 1'b0;
    ack      = 1'b1;
    tick;
    chk("sh_wb_en", {31'h0, wb_en}, 32'h1);
    chk("sh_wb_wen", {31'h0, wb_wen}, 32'h0);
    neg;
    ack = 1'b0;

    // LW then SW back to back, each acked in its first request cycle
    drive(1'b1, 5'd8, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick;
    chk("lw_req", {31'h0, req}, 32'h1);
    neg;
    ack   = 1'b1;
    rdata = 32'hCAFEF00D;
    drive(1'b1, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, 3'b010, 32'h408, 32'h55AA55AA);
    #1;
    chk("b2b_stall", {31'h0, stall}, 32'h0);
    tick;
    chk("b2b_lw_wb_en", {31'h0, wb_en}, 32'h1);
    chk("b2b_lw_wb_data", wb_data, 32'hCAFEF00D);
    chk("b2b_lw_wb_rd", {27'h0, wb_rd}, 32'd8);
    chk("b2b_sw_req", {31'h0, req}, 32'h1);
    chk("b2b_sw_we", {31'h0, we}, 32'h1);
    chk("b2b_sw_addr", addr, 32'h408);
    chk("b2b_sw_wstrb", {28'h0, wstrb}, 32'hF);
    chk("b2b_sw_wdata", wdata, 32'h55AA55AA);
    neg;
    ex_valid = 1'b0;
    tick;
    chk("b2b_sw_wb_en", {31'h0, wb_en}, 32'h1);
    chk("b2b_sw_wb_wen", {31'h0, wb_wen}, 32'h0);
    chk("b2b_req_clr", {31'h0, req}, 32'h0);
    neg;
    ack = 1'b0;

    // Stray ack in IDLE
    tick;
    neg;
    ack = 1'b1;
    tick;
    chk("stray_wb_en", {31'h0, wb_en}, 32'h0);
    chk("stray_req", {31'h0, req}, 32'h0);
    neg;
    ack = 1'b0;

    // Reset during WAIT abandons the access; a late ack is ignored
    drive(1'b1, 5'd10, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick;
    chk("rw_req", {31'h0, req}, 32'h1);
    neg;
    ex_valid = 1'b0;
    rst      = 1'b1;
    tick;
    chk("rw_req_clr", {31'h0, req}, 32'h0);
    chk("rw_clk_en", {31'h0, clk_en}, 32'h0);
    chk("rw_wb_en", {31'h0, wb_en}, 32'h0);
    neg;
    rst = 1'b0;
    ack = 1'b1;
    #1;
    chk("rw_late_stall", {31'h0, stall}, 32'h0);
    tick;
    chk("rw_late_wb_en", {31'h0, wb_en}, 32'h0);
    chk("rw_late_req", {31'h0, req}, 32'h0);
    neg;
    ack = 1'b0;

    // LW at 0x301
    drive(1'b1, 5'd11, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h301, 32'h0);
`ifdef MISALIGN_TRAP_EN
    tick;
    chk("mis_req", {31'h0, req}, 32'h0);
    chk("mis_clk_en", {31'h0, clk_en}, 32'h1);
    neg;
    ex_valid = 1'b0;
    tick;
    chk("mis_wb_en", {31'h0, wb_en}, 32'h1);
    chk("mis_flag", {31'h0, mis}, 32'h1);
    chk("mis_bad_addr", bad_addr, 32'h301);
    chk("mis_wb_wen", {31'h0, wb_wen}, 32'h0);
    tick;
    chk("mis_flag_end", {31'h0, mis}, 32'h0);
`else
    tick;
    chk("al_req", {31'h0, req}, 32'h1);
    chk("al_addr", addr, 32'h300);
    chk("al_wstrb", {28'h0, wstrb}, 32'hF);
    neg;
    ex_valid = 1'b0;
    ack      = 1'b1;
    rdata    = 32'h11223344;
    tick;
    chk("al_wb_en", {31'h0, wb_en}, 32'h1);
    chk("al_wb_data", wb_data, 32'h11223344);
    chk("al_mis", {31'h0, mis}, 32'h0);
    chk("al_bad_addr", bad_addr, 32'h0);
    neg;
    ack = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
